// File: rtl/mem_stage_pkg.sv
// Shared types for the memory / write-back stage: FSM state encoding, byte-enable
// patterns and the halfword sign-extension helper used on the load path.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    function automatic logic [31:0] sext_half(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/m_wb_stage_if.sv
// EX/M inputs, data-memory req/ack port and M->WB outputs of the memory stage.
// master = the stage itself, slave = the surrounding pipeline and memory.
interface m_wb_stage_if #(
    parameter int pc_size   = 18,
    parameter int data_size = 32,
    parameter int addr_size = 16
);
    logic                 M_MemtoReg;
    logic                 M_RegWrite;
    logic                 M_MemWrite;
    logic                 M_SH;
    logic                 M_LH;
    logic                 M_to_reg31;
    logic [data_size-1:0] M_ALU_result;
    logic [data_size-1:0] M_Rt_data;
    logic [pc_size-1:0]   M_PCplus8;
    logic [4:0]           M_WR_out;

    logic                 DM_req;
    logic                 DM_we;
    logic [addr_size-1:0] DM_addr;
    logic [data_size-1:0] DM_wdata;
    logic [3:0]           DM_be;
    logic                 DM_ack;
    logic [data_size-1:0] DM_rdata;

    logic                 M_stall;
    logic                 WB_RegWrite;
    logic [4:0]           WB_WR_out;
    logic [data_size-1:0] WB_WD;
    logic                 M_bus_err;

    modport master (
        input  M_MemtoReg, M_RegWrite, M_MemWrite, M_SH, M_LH, M_to_reg31,
               M_ALU_result, M_Rt_data, M_PCplus8, M_WR_out, DM_ack, DM_rdata,
        output DM_req, DM_we, DM_addr, DM_wdata, DM_be,
               M_stall, WB_RegWrite, WB_WR_out, WB_WD, M_bus_err
    );

    modport slave (
        output M_MemtoReg, M_RegWrite, M_MemWrite, M_SH, M_LH, M_to_reg31,
               M_ALU_result, M_Rt_data, M_PCplus8, M_WR_out, DM_ack, DM_rdata,
        input  DM_req, DM_we, DM_addr, DM_wdata, DM_be,
               M_stall, WB_RegWrite, WB_WR_out, WB_WD, M_bus_err
    );

endinterface

// File: rtl/mem_align.sv
// Lane steering for the data-memory port: store data replication, byte enables, load extraction.
// Purely combinational; lanes assume a 32-bit little-endian word.
module mem_align
    import mem_stage_pkg::*;
#(
    parameter int data_size = 32
) (
    input  logic                 sh_i,
    input  logic                 lh_i,
    input  logic                 addr1_i,
    input  logic [data_size-1:0] rt_i,
    input  logic [data_size-1:0] rdata_i,
    output logic [data_size-1:0] wdata_o,
    output logic [3:0]           be_o,
    output logic [data_size-1:0] load_o
);

    logic [15:0] rd_half;

    assign wdata_o = sh_i ? {rt_i[15:0], rt_i[15:0]} : rt_i;
    assign be_o    = sh_i ? (addr1_i ? BE_HI : BE_LO) : BE_WORD;

    assign rd_half = addr1_i ? rdata_i[31:16] : rdata_i[15:0];
    assign load_o  = lh_i ? sext_half(rd_half) : rdata_i;

endmodule

// File: rtl/m_wb_stage.sv
// Memory stage + M->WB register: non-memory ops pass through in one edge; an access takes >= 3 cycles.
// Holds M_stall high while a req/ack access is outstanding; all state changes on negedge clk.
// Optional MEM_TIMEOUT_EN: abort an unanswered access after TIMEOUT BUSY cycles and set a sticky M_bus_err.
module m_wb_stage
    import mem_stage_pkg::*;
#(
    parameter int pc_size   = 18,
    parameter int data_size = 32,
    parameter int addr_size = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = 16
`endif
) (
    input logic          clk,
    input logic          rst,
    m_wb_stage_if.master bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]           state_q, state_d;
    logic                 dm_req_q, dm_req_d;
    logic                 dm_we_q, dm_we_d;
    logic [addr_size-1:0] dm_addr_q, dm_addr_d;
    logic [data_size-1:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]           dm_be_q, dm_be_d;
    logic [data_size-1:0] ld_q, ld_d;
    logic                 wb_rw_q, wb_rw_d;
    logic [4:0]           wb_wr_q, wb_wr_d;
    logic [data_size-1:0] wb_wd_q, wb_wd_d;

    logic                 access;
    logic [data_size-1:0] al_wdata, al_load, wd_sel;
    logic [3:0]           al_be;
    logic                 unused_alu_bits;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    assign access          = bus.M_MemtoReg | bus.M_MemWrite;
    assign unused_alu_bits = ^{bus.M_ALU_result[data_size-1:addr_size], bus.M_ALU_result[0]};

    mem_align #(.data_size(data_size)) u_align (
        .sh_i    (bus.M_MemWrite & bus.M_SH),
        .lh_i    (bus.M_LH),
        .addr1_i (bus.M_ALU_result[1]),
        .rt_i    (bus.M_Rt_data),
        .rdata_i (bus.DM_rdata),
        .wdata_o (al_wdata),
        .be_o    (al_be),
        .load_o  (al_load)
    );

    // Loads only reach this mux from DONE, so ld_q always holds the finished access.
    assign wd_sel = bus.M_to_reg31 ? {{(data_size-pc_size){1'b0}}, bus.M_PCplus8}
                  : bus.M_MemtoReg ? ld_q
                  : bus.M_ALU_result;

    always_comb begin
        state_d    = state_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        ld_d       = ld_q;
        wb_rw_d    = wb_rw_q;
        wb_wr_d    = wb_wr_q;
        wb_wd_d    = wb_wd_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d      = '0;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    wb_rw_d    = 1'b0;
                    dm_req_d   = 1'b1;
                    dm_we_d    = bus.M_MemWrite;
                    dm_addr_d  = {bus.M_ALU_result[addr_size-1:2], 2'b00};
                    dm_wdata_d = al_wdata;
                    dm_be_d    = al_be;
                    state_d    = S_BUSY;
                end else begin
                    wb_rw_d = bus.M_RegWrite;
                    wb_wr_d = bus.M_WR_out;
                    wb_wd_d = wd_sel;
                end
            end
            S_BUSY: begin
                wb_rw_d = 1'b0;
                if (bus.DM_ack) begin
                    ld_d     = al_load;
                    dm_req_d = 1'b0;
                    state_d  = S_DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ld_d     = '0;
                    dm_req_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                wb_rw_d = bus.M_RegWrite;
                wb_wr_d = bus.M_WR_out;
                wb_wd_d = wd_sel;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_be_q    <= '0;
            ld_q       <= '0;
            wb_rw_q    <= 1'b0;
            wb_wr_q    <= '0;
            wb_wd_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            ld_q       <= ld_d;
            wb_rw_q    <= wb_rw_d;
            wb_wr_q    <= wb_wr_d;
            wb_wd_q    <= wb_wd_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign bus.M_stall     = (state_q == S_BUSY) | ((state_q == S_IDLE) & access);
    assign bus.DM_req      = dm_req_q;
    assign bus.DM_we       = dm_we_q;
    assign bus.DM_addr     = dm_addr_q;
    assign bus.DM_wdata    = dm_wdata_q;
    assign bus.DM_be       = dm_be_q;
    assign bus.WB_RegWrite = wb_rw_q;
    assign bus.WB_WR_out   = wb_wr_q;
    assign bus.WB_WD       = wb_wd_q;
`ifdef MEM_TIMEOUT_EN
    assign bus.M_bus_err   = err_q;
`else
    assign bus.M_bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_m_wb_stage.sv
// Directed + randomized bench for m_wb_stage; expected values come from a transaction-level model.
module tb_m_wb_stage;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    m_wb_stage_if bus ();

    m_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Updates happen on negedge; everything is driven and sampled 1 time unit after it.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return h[15] ? {16'hFFFF, h} : {16'h0000, h};
    endfunction

    task automatic drive(input logic mtr, mw, sh, lh, t31, rw,
                         input logic [31:0] alu, rt, input logic [17:0] pc8, input logic [4:0] wr);
        bus.M_MemtoReg   = mtr;
        bus.M_MemWrite   = mw;
        bus.M_SH         = sh;
        bus.M_LH         = lh;
        bus.M_to_reg31   = t31;
        bus.M_RegWrite   = rw;
        bus.M_ALU_result = alu;
        bus.M_Rt_data    = rt;
        bus.M_PCplus8    = pc8;
        bus.M_WR_out     = wr;
    endtask

    // One instruction through the stage; nbusy = BUSY cycles, ack arrives in the last one.
    task automatic run_txn(input string tag, input logic mtr, mw, sh, lh, t31, rw,
                           input logic [31:0] alu, rt, input logic [17:0] pc8,
                           input logic [4:0] wr, input logic [31:0] rd, input int nbusy);
        logic        acc;
        logic [31:0] exp_wd, ld, exp_wdata;
        logic [3:0]  exp_be;
        int          stalls;
        acc = mtr | mw;
        drive(mtr, mw, sh, lh, t31, rw, alu, rt, pc8, wr);
        bus.DM_ack   = 1'($urandom_range(0, 1));
        bus.DM_rdata = $urandom;
        #1;
        ld        = lh ? sext16(alu[1] ? rd[31:16] : rd[15:0]) : rd;
        exp_wd    = t31 ? {14'd0, pc8} : (mtr ? ld : alu);
        exp_be    = (mw && sh) ? (alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        exp_wdata = (mw && sh) ? {rt[15:0], rt[15:0]} : rt;
        stalls    = 0;
        if (acc) begin
            if (bus.M_stall === 1'b1) stalls++;
            tick();
            bus.DM_ack = 1'b0;
            chk({tag, ".req"}, 32'(bus.DM_req), 32'd1);
            chk({tag, ".we"}, 32'(bus.DM_we), 32'(mw));
            chk({tag, ".addr"}, 32'(bus.DM_addr), 32'(alu[15:0] & 16'hFFFC));
            chk({tag, ".be"}, 32'(bus.DM_be), 32'(exp_be));
            if (mw) chk({tag, ".wdata"}, bus.DM_wdata, exp_wdata);
            chk({tag, ".bubble"}, 32'(bus.WB_RegWrite), 32'd0);
            for (int i = 1; i <= nbusy; i++) begin
                if (i == nbusy) begin
                    bus.DM_ack   = 1'b1;
                    bus.DM_rdata = rd;
                end
                #1;
                if (bus.M_stall === 1'b1) stalls++;
                tick();
                bus.DM_ack   = 1'b0;
                bus.DM_rdata = $urandom;
            end
            bus.DM_ack = 1'($urandom_range(0, 1));
            #1;
            chk({tag, ".req_drop"}, 32'(bus.DM_req), 32'd0);
            chk({tag, ".stall_cycles"}, 32'(stalls), 32'(nbusy + 1));
            chk({tag, ".done_bubble"}, 32'(bus.WB_RegWrite), 32'd0);
        end
        chk({tag, ".stall_low"}, 32'(bus.M_stall), 32'd0);
        tick();
        chk({tag, ".wb_rw"}, 32'(bus.WB_RegWrite), 32'(rw));
        chk({tag, ".wb_wr"}, 32'(bus.WB_WR_out), 32'(wr));
        chk({tag, ".wb_wd"}, bus.WB_WD, exp_wd);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 18'd0, 5'd0);
        bus.DM_ack   = 1'b0;
        bus.DM_rdata = '0;
        #12;
        chk("rst.req", 32'(bus.DM_req), 32'd0);
        chk("rst.we", 32'(bus.DM_we), 32'd0);
        chk("rst.addr", 32'(bus.DM_addr), 32'd0);
        chk("rst.wdata", bus.DM_wdata, 32'd0);
        chk("rst.be", 32'(bus.DM_be), 32'd0);
        chk("rst.wb_rw", 32'(bus.WB_RegWrite), 32'd0);
        chk("rst.wb_wr", 32'(bus.WB_WR_out), 32'd0);
        chk("rst.wb_wd", bus.WB_WD, 32'd0);
        chk("rst.stall", 32'(bus.M_stall), 32'd0);
        chk("rst.err", 32'(bus.M_bus_err), 32'd0);
        @(posedge clk);
        rst = 1'b1;
        tick();

        run_txn("alu", 0, 0, 0, 0, 0, 1, 32'h1234, 32'h0, 18'h0, 5'd8, 32'h0, 1);
        run_txn("sw", 0, 1, 0, 0, 0, 0, 32'h0010, 32'hDEADBEEF, 18'h0, 5'd0, 32'h0, 2);
        run_txn("sh", 0, 1, 1, 0, 0, 0, 32'h0012, 32'h0000ABCD, 18'h0, 5'd0, 32'h0, 1);
        run_txn("lh_hi", 1, 0, 0, 1, 0, 1, 32'h0006, 32'h0, 18'h0, 5'd9, 32'h80010002, 1);
        run_txn("lh_lo", 1, 0, 0, 1, 0, 1, 32'h0004, 32'h0, 18'h0, 5'd10, 32'h80010002, 3);
        run_txn("jal", 0, 0, 0, 0, 1, 1, 32'hCAFE, 32'h0, 18'h00104, 5'd31, 32'h0, 1);
        run_txn("lw", 1, 0, 0, 0, 0, 1, 32'h0020, 32'h0, 18'h0, 5'd11, 32'h12345678, 1);

        // Reset while BUSY: request dropped and the FSM back in IDLE at once.
        drive(1, 0, 0, 0, 0, 1, 32'h0040, 32'h0, 18'h0, 5'd3);
        bus.DM_ack = 1'b0;
        tick();
        chk("rstbusy.req_before", 32'(bus.DM_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("rstbusy.req", 32'(bus.DM_req), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 18'd0, 5'd0);
        #1;
        chk("rstbusy.idle", 32'(bus.M_stall), 32'd0);
        chk("rstbusy.wb_wd", bus.WB_WD, 32'd0);
        @(posedge clk);
        rst = 1'b1;
        tick();
        run_txn("post_rst", 0, 0, 0, 0, 0, 1, 32'h55AA, 32'h0, 18'h0, 5'd4, 32'h0, 1);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] alu, rt, rd;
            logic [17:0] pc8;
            logic [4:0]  wr;
            int          nb;
            alu = $urandom;
            rt  = $urandom;
            rd  = $urandom;
            pc8 = 18'($urandom);
            wr  = 5'($urandom);
            nb  = $urandom_range(1, 4);
            case ($urandom_range(0, 5))
                0: run_txn("r_alu", 0, 0, 0, 0, 0, 1, alu, rt, pc8, wr, rd, nb);
                1: run_txn("r_jal", 0, 0, 0, 0, 1, 1, alu, rt, pc8, wr, rd, nb);
                2: run_txn("r_lw", 1, 0, 0, 0, 0, 1, alu, rt, pc8, wr, rd, nb);
                3: run_txn("r_lh", 1, 0, 0, 1, 0, 1, alu, rt, pc8, wr, rd, nb);
                4: run_txn("r_sw", 0, 1, 0, 0, 0, 0, alu, rt, pc8, wr, rd, nb);
                default: run_txn("r_sh", 0, 1, 1, 0, 0, 0, alu, rt, pc8, wr, rd, nb);
            endcase
        end

`ifdef MEM_TIMEOUT_EN
        drive(1, 0, 0, 0, 0, 1, 32'h0080, 32'h0, 18'h0, 5'd12);
        bus.DM_ack = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo.still_busy", 32'(bus.M_stall), 32'd1);
        tick();
        chk("tmo.done", 32'(bus.M_stall), 32'd0);
        chk("tmo.err", 32'(bus.M_bus_err), 32'd1);
        tick();
        chk("tmo.wb_wd", bus.WB_WD, 32'd0);
        run_txn("tmo.after", 0, 0, 0, 0, 0, 1, 32'h77, 32'h0, 18'h0, 5'd5, 32'h0, 1);
        chk("tmo.sticky", 32'(bus.M_bus_err), 32'd1);
`else
        chk("err_tied", 32'(bus.M_bus_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
